// File: rtl/pattern_sched_pkg.sv
// Shared types and width helpers for the pattern scan scheduler.
// ID_W and CNT_W are the widths for the default NREQ=4 and WORD_W=8.
package pattern_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int cnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

  localparam int ID_W  = id_w(4);
  localparam int CNT_W = cnt_w(8);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping from NREQ-1 back to 0. NREQ must be a power of two.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic          found;
  logic [IW-1:0] idx;

  // Index arithmetic wraps for free because NREQ == 2**IW.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_scheduler.sv
// Round-robin job scheduler. Each granted word is scanned MSB first, and the
// block reports how many times the configured bit pattern occurs in it.
module pattern_scan_scheduler
  import pattern_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int PAT_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WORD_W-1:0]      req_data,
  output logic [NREQ-1:0]             req_ready,
  input  logic [PAT_W-1:0]            cfg_pattern,
  output logic                        res_valid,
  output logic [id_w(NREQ)-1:0]       res_id,
  output logic [cnt_w(WORD_W)-1:0]    res_count,
  output logic                        busy
);

  localparam int IW = id_w(NREQ);
  localparam int CW = cnt_w(WORD_W);
  localparam logic [CW-1:0] PAT_LEN    = CW'(PAT_W);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WORD_W - 1);

  logic [WORD_W-1:0] words [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign words[gi] = req_data[gi*WORD_W +: WORD_W];
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [IW-1:0]     id_q, id_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [CW-1:0]     nshift_q, nshift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [IW-1:0]     res_id_q, res_id_d;
  logic [CW-1:0]     res_count_q, res_count_d;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     g_idx;
  logic              accept;
  logic              match;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign accept    = |(req_ready & req_valid);

  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) g_idx = IW'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    pat_d       = pat_q;
    id_d        = id_q;
    hist_d      = hist_q;
    nshift_d    = nshift_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_count_d = res_count_q;
    match       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          data_d   = words[g_idx];
          pat_d    = cfg_pattern;
          id_d     = g_idx;
          ptr_d    = g_idx + IW'(1);
          hist_d   = '0;
          nshift_d = '0;
          cnt_d    = '0;
        end
      end
      ST_SHIFT: begin
        hist_d   = {hist_q[PAT_W-2:0], data_q[WORD_W-1]};
        data_d   = data_q << 1;
        nshift_d = nshift_q + CW'(1);
        // Only windows lying fully inside the current word may match.
        match    = (nshift_d >= PAT_LEN) && (hist_d == pat_q);
        cnt_d    = cnt_q + CW'(match);
        if (nshift_q == LAST_SHIFT) begin
          state_d     = ST_REPORT;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_count_d = cnt_d;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      data_q      <= '0;
      pat_q       <= '0;
      id_q        <= '0;
      hist_q      <= '0;
      nshift_q    <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      pat_q       <= pat_d;
      id_q        <= id_d;
      hist_q      <= hist_d;
      nshift_q    <= nshift_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Directed and randomized bench for pattern_scan_scheduler. It checks results
// against a sliding-window match counter and a round-robin pointer model.
module tb_pattern_scan_scheduler;
  import pattern_sched_pkg::*;

  localparam int NREQ   = 4;
  localparam int WORD_W = 8;
  localparam int PAT_W  = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*WORD_W-1:0]   req_data;
  logic [NREQ-1:0]          req_ready;
  logic [PAT_W-1:0]         cfg_pattern;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic [CNT_W-1:0]         res_count;
  logic                     busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;
  int rr_ptr_m = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_scan_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_pattern (cfg_pattern),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_count   (res_count),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count every PAT_W-bit window of the word (read MSB first) equal to the pattern.
  function automatic int model_count(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p);
    int c;
    logic [WORD_W-1:0] win;
    c = 0;
    for (int s = 0; s <= WORD_W - PAT_W; s++) begin
      win = w >> (WORD_W - PAT_W - s);
      if (win[PAT_W-1:0] == p) c++;
    end
    return c;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(rr_ptr_m + k) % NREQ]) return (rr_ptr_m + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic do_job(input string tag, input logic [NREQ-1:0] mask,
                        input logic [NREQ*WORD_W-1:0] data, input logic [PAT_W-1:0] pat,
                        input int exp_id, input int exp_cnt, input bit hold, input bit check_gap);
    int g, eid, ecnt, k;
    logic [WORD_W-1:0] w;
    req_valid   = mask;
    req_data    = data;
    cfg_pattern = pat;
    #1;
    g    = model_grant(mask);
    w    = data[g*WORD_W +: WORD_W];
    eid  = (exp_id >= 0) ? exp_id : g;
    ecnt = (exp_cnt >= 0) ? exp_cnt : model_count(w, pat);
    chk({tag, " ready"}, 32'(req_ready), 32'(1) << eid);
    @(posedge clk);
    #2;
    if (check_gap) chk({tag, " gap"}, 32'(cyc - last_acc), 32'(WORD_W + 2));
    last_acc = cyc;
    rr_ptr_m = (g + 1) % NREQ;
    if (!hold) req_valid = '0;
    req_data    = $urandom;
    cfg_pattern = ~pat;
    #1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
    k = 1;
    while (res_valid !== 1'b1 && k < 3 * WORD_W) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(WORD_W + 1));
    chk({tag, " res_id"}, 32'(res_id), 32'(eid));
    chk({tag, " res_count"}, 32'(res_count), 32'(ecnt));
    $display("job %s: id %0d count %0d latency %0d", tag, res_id, res_count, k);
    tick();
    chk({tag, " strobe"}, 32'(res_valid), 32'd0);
    chk({tag, " id_hold"}, 32'(res_id), 32'(eid));
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    logic [NREQ-1:0] m;
    logic [NREQ*WORD_W-1:0] d;
    logic [PAT_W-1:0] p;
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] sh;

    rst = 1'b1; req_valid = '1; req_data = '0; cfg_pattern = '0;
    tick();
    tick();
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_id", 32'(res_id), 32'd0);
    chk("rst res_count", 32'(res_count), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0; req_valid = '0;
    tick();

    do_job("s1", 4'b0001, {24'h0, 8'b00110011}, 5'b00110, 0, 1, 1'b0, 1'b0);
    do_job("s2", 4'b0001, {24'h0, 8'b10101010}, 5'b10101, 0, 2, 1'b0, 1'b0);
    do_job("s3", 4'b0001, {24'h0, 8'hFF}, 5'b00110, 0, 0, 1'b0, 1'b0);
    do_job("s5a", 4'b0001, {24'h0, 8'b11110011}, 5'b00110, 0, 0, 1'b0, 1'b0);
    do_job("s5b", 4'b0010, {16'h0, 8'b01111111, 8'h00}, 5'b00110, 1, 0, 1'b0, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_ptr_m = 0;
    for (int j = 0; j < 5; j++) begin
      do_job("s4", 4'b1111, $urandom, PAT_W'($urandom), j % NREQ, -1, 1'b1, j > 0);
    end
    req_valid = '0;
    tick();

    req_valid = 4'b0100; req_data = $urandom; cfg_pattern = 5'b00110;
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1; req_valid = 4'b0110;
    #1;
    chk("s6 ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    rr_ptr_m = 0;
    chk("s6 res_id_rst", 32'(res_id), 32'd0);
    chk("s6 busy_rst", 32'(busy), 32'd0);
    seen = 0;
    for (int j = 0; j < 12; j++) begin
      if (res_valid === 1'b1) seen++;
      tick();
    end
    chk("s6 aborted", 32'(seen), 32'd0);
    do_job("s6", 4'b0110, $urandom, PAT_W'($urandom), 1, -1, 1'b0, 1'b0);

    for (int j = 0; j < 10; j++) begin
      m = NREQ'($urandom_range(1, 15));
      d = $urandom;
      w = d[model_grant(m)*WORD_W +: WORD_W];
      sh = w >> $urandom_range(0, WORD_W - PAT_W);
      p = (j % 2 == 0) ? sh[PAT_W-1:0] : PAT_W'($urandom);
      do_job("rnd", m, d, p, -1, -1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pattern_scan_scheduler.md
PATTERN_SCAN_SCHEDULER -- requirements
Module: pattern_scan_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (power of two, 2..8).
REQ-002 The block SHALL have parameter WORD_W, default 8, bits per request word.
REQ-003 The block SHALL have parameter PAT_W, default 5, pattern length in bits (2..WORD_W).
REQ-004 The block SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid  input  NREQ  bit i = requester i has a word pending.
REQ-007 The block SHALL have port req_data  input  NREQ*WORD_W  requester i word at [i*WORD_W +: WORD_W].
REQ-008 The block SHALL have port req_ready  output  NREQ  one-hot grant, combinational from state, pointer and req_valid.
REQ-009 The block SHALL have port cfg_pattern  input  PAT_W  target pattern; first-received bit is MSB.
REQ-010 The block SHALL have port res_valid  output  1  one-cycle result strobe.
REQ-011 The block SHALL have port res_id  output  clog2(NREQ)  requester index of the result.
REQ-012 The block SHALL have port res_count  output  clog2(WORD_W+1)  number of matches in the word.
REQ-013 The block SHALL have port busy  output  1  high in SHIFT and REPORT.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and REPORT.
- IDLE -> SHIFT on accept.
- SHIFT -> REPORT after exactly WORD_W shift cycles.
- REPORT -> IDLE unconditionally.
REQ-015 In IDLE with any req_valid set, req_ready SHALL assert only for the granted index g: first set bit at or after rr_ptr, wrapping NREQ-1 -> 0.
REQ-016 Accept SHALL occur when req_valid[g] & req_ready[g]; on accept, req_data[g], cfg_pattern and g SHALL be latched, and rr_ptr SHALL become (g+1) mod NREQ.
REQ-017 req_ready SHALL be all-zero outside IDLE and when req_valid is zero; a requester dropping valid without grant SHALL not be served.
REQ-018 SHIFT SHALL feed one latched bit per cycle, MSB first, into a PAT_W-bit history register cleared on accept.
REQ-019 A match SHALL be counted on a cycle when at least PAT_W bits of the current word have been shifted and history equals the latched pattern; overlapping matches SHALL count.
REQ-020 History SHALL NOT carry across words; a pattern spanning two words SHALL not count.
REQ-021 res_count SHALL saturate-free range 0..WORD_W-PAT_W+1 and SHALL be registered.
REQ-022 Latency: accept at cycle T -> res_valid high at cycle T+WORD_W+1 for exactly one cycle, with res_id/res_count valid that cycle; the next accept SHALL be possible at T+WORD_W+2.
REQ-023 res_valid SHALL have no backpressure; res_id and res_count SHALL hold their last value when res_valid is low.
REQ-024 cfg_pattern changes after accept SHALL NOT affect the job in flight.

Reset
REQ-025 With rst high at a clock edge, the block SHALL enter IDLE, set rr_ptr=0, res_valid=0, res_id=0, res_count=0, busy=0 and clear history and counters.
REQ-026 rst during SHIFT or REPORT SHALL abort the job with no res_valid for it; req_ready SHALL be 0 while rst is high.

Structure
REQ-027 Package pattern_sched_pkg SHALL hold the state enum and the width helper constants (ID_W, CNT_W).
REQ-028 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-029 Scenario 1: pattern 5'b00110, req 0 data 8'b00110011 -> res_valid at T+9, res_id=0, res_count=1.
REQ-030 Scenario 2: pattern 5'b10101, data 8'b10101010 -> res_count=2 (overlap counted).
REQ-031 Scenario 3: pattern 5'b00110, data 8'hFF -> res_count=0.
REQ-032 Scenario 4: all four req_valid high from reset, held -> grants 0,1,2,3,0 in order, accepts 10 cycles apart, res_id sequence 0,1,2,3.
REQ-033 Scenario 5: pattern 5'b00110; word A 8'b11110011, then word B 8'b01111111 -> both res_count=0 (no cross-word match).
REQ-034 Scenario 6: rst pulse 1 cycle during SHIFT of requester 2 -> no res_valid for it; with req 1 and 2 valid afterwards, the first grant is requester 1 (rr_ptr=0).
